cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
// Shares one physical-memory port between the I-cache and D-cache miss/writeback paths.
// Sits between the two cache_control instances' downstream handshakes and the single
// pmem port. Grants one requester at a time, round-robin on contention, and holds the
// grant until pmem_resp. Keeps per-requester grant counters for performance tracking.
// PARAMETERS
// ADDR_W   32   address width, byte address of line
// LINE_W   256  cache line width in bits
// CNT_W    32   width of grant performance counters
// PORTS
// clk          in   1       clock; all state on rising edge
// rst_n        in   1       asynchronous, active-low reset
// i_read       in   1       I-cache line read request, held until i_resp
// i_address    in   ADDR_W  I-cache line address
// i_resp       out  1       I-cache transaction done
// i_rdata      out  LINE_W  line returned to I-cache
// d_read       in   1       D-cache line read request, held until d_resp
// d_write      in   1       D-cache line writeback request, held until d_resp
// d_address    in   ADDR_W  D-cache line address
// d_wdata      in   LINE_W  D-cache writeback data
// d_resp       out  1       D-cache transaction done
// d_rdata      out  LINE_W  line returned to D-cache
// pmem_read    out  1       memory read strobe
// pmem_write   out  1       memory write strobe
// pmem_address out  ADDR_W  memory address
// pmem_wdata   out  LINE_W  memory write data
// pmem_rdata   in   LINE_W  memory read data
// pmem_resp    in   1       memory transaction done
// i_grant_cnt  out  CNT_W   number of completed I-cache transactions
// d_grant_cnt  out  CNT_W   number of completed D-cache transactions
// BEHAVIOUR
// - States: IDLE, SERVE_I, SERVE_D. Reset: state=IDLE, last_grant=I, both counters 0.
// - Reset value of every output: 0. An rst_n assertion mid-transaction aborts to IDLE
//   at once; pmem strobes drop asynchronously. The memory model is reset alongside.
// - IDLE: no pmem strobes and no resps. req_i=i_read; req_d=d_read|d_write.
//   Only req_i -> SERVE_I. Only req_d -> SERVE_D. Both -> the side != last_grant.
//   With last_grant=I after reset, D wins the first tie. Neither -> stay.
// - Latency: a request sampled in IDLE at edge N drives pmem strobes from cycle N+1.
//   There is no combinational IDLE bypass.
// - SERVE_x: pmem_read/pmem_write/pmem_address/pmem_wdata pass through combinationally
//   from the granted side. Strobes are gated by (~pmem_resp), so they drop in the resp cycle.
//   SERVE_I drives pmem_write=0 and pmem_wdata=0.
//   x_resp = pmem_resp in SERVE_x, else 0. The ungranted side's resp is always 0.
// - i_rdata = d_rdata = pmem_rdata (broadcast). Only meaningful while the matching resp is high.
// - On pmem_resp in SERVE_x: next state=IDLE, last_grant<=x, x_grant_cnt<=+1.
//   Counter wraps modulo 2^CNT_W.
//   This gives one dead IDLE cycle between back-to-back transactions by design.
// - D-cache miss with writeback arrives as two transactions (read, then write).
//   The write re-arbitrates and may lose one round to a pending I-cache read.
// - Granted side drops all its requests before pmem_resp (protocol violation):
//   next state=IDLE, no counter increment, last_grant unchanged.
// - d_read and d_write both high: both strobes are forwarded. This is illegal; the bench asserts on it.
// - A requester's inputs changing while ungranted have no effect on the pmem outputs.
// STRUCTURE
// - Add arb_state_t {IDLE, SERVE_I, SERVE_D} and arb_grant_t {GRANT_I, GRANT_D}
//   to the shared package rv32i_types.
// - Sub-module rr_pick2: pure combinational 2-way round-robin pick (req_i, req_d,
//   last_grant -> grant). Reused later for an L2 port arbiter.
// - Top contains the state register, last_grant register, output mux and the two counters.
// TESTING
// - Reset: hold rst_n=0 with i_read=1 -> all outputs 0. Release -> pmem_read=1 at
//   pmem_address=i_address one cycle later.
// - Lone I-read 0x100, memory resp after 5 cycles -> i_resp=1 for 1 cycle with i_rdata=pattern,
//   d_resp=0, i_grant_cnt=1.
// - Simultaneous i_read@0x200 and d_read@0x300 from reset -> D served first. After d_resp,
//   one IDLE cycle, then I served. Final counters i=1, d=1.
// - D writeback d_write@0x400 with wdata=0xA5.. while i_read pending since last_grant=D ->
//   I served before the writeback. pmem_wdata=0xA5.. seen only during SERVE_D.
// - rst_n pulsed low mid SERVE_D -> pmem_write drops same cycle, state IDLE, counters 0.
// - Preload d_grant_cnt to 2^CNT_W-1 via force, complete a D transaction -> counter wraps to 0.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the rv32i memory hierarchy
package rv32i_types;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_LINE_W = 256;
    localparam int unsigned ARB_CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin pick
module rr_pick2
    import rv32i_types::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  arb_grant_t last_grant,
    output arb_grant_t grant
);

    // On a tie the side that did not win last time goes next.
    always_comb begin
        grant = GRANT_I;
        if (req_i && req_d) begin
            grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (req_d) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - shares one pmem port between I-cache and D-cache
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned LINE_W = ARB_LINE_W,
    parameter int unsigned CNT_W  = ARB_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    arb_state_t state;
    arb_state_t state_next;
    arb_grant_t last_grant;
    arb_grant_t pick;
    logic       req_i;
    logic       req_d;
    logic       done_i;
    logic       done_d;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    rr_pick2 u_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant),
        .grant      (pick)
    );

    assign done_i = (state == SERVE_I) && pmem_resp;
    assign done_d = (state == SERVE_D) && pmem_resp;

    // A granted side withdrawing its request early also returns to IDLE, without credit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    state_next = (pick == GRANT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                if (pmem_resp || !req_i) begin
                    state_next = IDLE;
                end
            end
            SERVE_D: begin
                if (pmem_resp || !req_d) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= GRANT_I;
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else begin
            state <= state_next;
            if (done_i) begin
                last_grant  <= GRANT_I;
                i_grant_cnt <= i_grant_cnt + CNT_W'(1);
            end
            if (done_d) begin
                last_grant  <= GRANT_D;
                d_grant_cnt <= d_grant_cnt + CNT_W'(1);
            end
        end
    end

    // Strobes fall in the response cycle so memory never sees a second request.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (state)
            SERVE_I: begin
                pmem_read    = i_read & ~pmem_resp;
                pmem_address = i_address;
                i_resp       = pmem_resp;
            end
            SERVE_D: begin
                pmem_read    = d_read & ~pmem_resp;
                pmem_write   = d_write & ~pmem_resp;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                d_resp       = pmem_resp;
            end
            default: ;
        endcase
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter
module tb_cache_arbiter;
    import rv32i_types::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read, d_read, d_write;
    logic [31:0]  i_address, d_address, pmem_address;
    logic [255:0] d_wdata, i_rdata, d_rdata, pmem_wdata, pmem_rdata;
    logic         i_resp, d_resp, pmem_read, pmem_write, pmem_resp;
    logic [31:0]  i_grant_cnt, d_grant_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int mem_lat = 5;
    bit rand_lat = 1'b0;
    int lat_cnt;
    logic [255:0] mem     [logic [31:0]];
    logic [255:0] ref_mem [logic [31:0]];
    int i_done, d_done;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    function automatic logic [255:0] pat(input logic [31:0] a);
        return {8{a ^ 32'h5EED_0000}};
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    // Memory model: answers lat cycles after a strobe appears, one-cycle resp pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            lat_cnt    <= 0;
        end else if (pmem_resp) begin
            pmem_resp <= 1'b0;
            lat_cnt   <= 0;
        end else if (pmem_read || pmem_write) begin
            if (lat_cnt >= mem_lat - 1) begin
                if (pmem_write) mem[pmem_address] = pmem_wdata;
                pmem_rdata <= mem.exists(pmem_address) ? mem[pmem_address] : pat(pmem_address);
                pmem_resp  <= 1'b1;
                lat_cnt    <= 0;
                if (rand_lat) mem_lat = $urandom_range(1, 6);
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) assert (!(d_read && d_write)) else $error("FAIL illegal_dual_req d_read and d_write both high");
    end

    task automatic clear_inputs();
        i_read = 0; d_read = 0; d_write = 0;
        i_address = 0; d_address = 0; d_wdata = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        mem_lat = 5; rand_lat = 1'b0;
        mem.delete(); ref_mem.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_resp(input bit is_d, output logic [255:0] data, output int cyc, output bit ok);
        ok = 1'b0; cyc = 0; data = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (is_d ? d_resp : i_resp) begin
                ok = 1'b1;
                data = is_d ? d_rdata : i_rdata;
                break;
            end
            cyc++;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL resp_timeout side=%0d got no resp required resp within 200 cycles", is_d); end
    endtask

    task automatic test_reset();
        logic [255:0] data; int cyc; bit ok;
        rst_n = 1'b0; clear_inputs();
        i_read = 1; i_address = 32'h40;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 || pmem_address !== 0 || pmem_wdata !== 0) begin
            n_fail++; $display("FAIL reset_ctrl got rd=%b wr=%b ir=%b dr=%b a=%h required all 0", pmem_read, pmem_write, i_resp, d_resp, pmem_address);
        end
        n_tests++;
        if (i_grant_cnt !== 0 || d_grant_cnt !== 0 || i_rdata !== 0 || d_rdata !== 0) begin
            n_fail++; $display("FAIL reset_data got icnt=%0d dcnt=%0d required 0", i_grant_cnt, d_grant_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h40) begin
            n_fail++; $display("FAIL reset_release got rd=%b a=%h required rd=1 a=00000040", pmem_read, pmem_address);
        end
        wait_resp(0, data, cyc, ok);
        i_read = 0;
    endtask

    task automatic test_lone_iread();
        logic [255:0] data; int cyc; bit ok;
        do_reset();
        i_read = 1; i_address = 32'h100;
        wait_resp(0, data, cyc, ok);
        n_tests++;
        if (cyc !== mem_lat) begin n_fail++; $display("FAIL lone_latency got %0d required %0d", cyc, mem_lat); end
        n_tests++;
        if (data !== pat(32'h100) || d_resp !== 1'b0) begin
            n_fail++; $display("FAIL lone_data got %h dresp=%b required %h dresp=0", data, d_resp, pat(32'h100));
        end
        i_read = 0;
        @(negedge clk);
        n_tests++;
        if (i_resp !== 1'b0 || i_grant_cnt !== 1 || d_grant_cnt !== 0) begin
            n_fail++; $display("FAIL lone_after got iresp=%b icnt=%0d dcnt=%0d required 0 1 0", i_resp, i_grant_cnt, d_grant_cnt);
        end
    endtask

    task automatic test_tie();
        logic [255:0] data; int cyc; bit ok;
        do_reset();
        i_read = 1; i_address = 32'h200;
        d_read = 1; d_address = 32'h300;
        @(negedge clk);
        n_tests++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h300) begin
            n_fail++; $display("FAIL tie_first got rd=%b a=%h required rd=1 a=00000300", pmem_read, pmem_address);
        end
        wait_resp(1, data, cyc, ok);
        n_tests++;
        if (data !== pat(32'h300) || i_resp !== 1'b0) begin n_fail++; $display("FAIL tie_ddata got %h required %h", data, pat(32'h300)); end
        d_read = 0;
        @(negedge clk);
        n_tests++;
        if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL tie_dead got rd=%b required 0", pmem_read); end
        @(negedge clk);
        n_tests++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h200) begin
            n_fail++; $display("FAIL tie_second got rd=%b a=%h required rd=1 a=00000200", pmem_read, pmem_address);
        end
        wait_resp(0, data, cyc, ok);
        i_read = 0;
        @(negedge clk);
        n_tests++;
        if (i_grant_cnt !== 1 || d_grant_cnt !== 1) begin
            n_fail++; $display("FAIL tie_counts got i=%0d d=%0d required 1 1", i_grant_cnt, d_grant_cnt);
        end
    endtask

    task automatic test_writeback();
        logic [255:0] data; int cyc; bit ok;
        logic [255:0] wd;
        wd = {32{8'hA5}};
        do_reset();
        d_read = 1; d_address = 32'h500;
        wait_resp(1, data, cyc, ok);
        d_read = 0; d_write = 1; d_address = 32'h400; d_wdata = wd;
        i_read = 1; i_address = 32'h600;
        @(negedge clk);
        n_tests++;
        if (pmem_write !== 1'b0 || pmem_wdata !== 0) begin n_fail++; $display("FAIL wb_dead got wr=%b wd=%h required 0", pmem_write, pmem_wdata); end
        @(negedge clk);
        n_tests++;
        if (pmem_address !== 32'h600 || pmem_write !== 1'b0 || pmem_wdata !== 0 || pmem_read !== 1'b1) begin
            n_fail++; $display("FAIL wb_iserve got a=%h wr=%b wd=%h required a=00000600 wr=0 wd=0", pmem_address, pmem_write, pmem_wdata);
        end
        wait_resp(0, data, cyc, ok);
        i_read = 0;
        @(negedge clk);
        n_tests++;
        if (pmem_wdata !== 0) begin n_fail++; $display("FAIL wb_dead2 got wd=%h required 0", pmem_wdata); end
        @(negedge clk);
        n_tests++;
        if (pmem_write !== 1'b1 || pmem_wdata !== wd || pmem_address !== 32'h400) begin
            n_fail++; $display("FAIL wb_dserve got wr=%b a=%h wd=%h required wr=1 a=00000400 wd=%h", pmem_write, pmem_address, pmem_wdata, wd);
        end
        wait_resp(1, data, cyc, ok);
        ref_mem[32'h400] = wd;
        d_write = 0;
        i_read = 1; i_address = 32'h400;
        wait_resp(0, data, cyc, ok);
        n_tests++;
        if (data !== ref_line(32'h400)) begin n_fail++; $display("FAIL wb_readback got %h required %h", data, ref_line(32'h400)); end
        i_read = 0;
    endtask

    task automatic test_reset_mid();
        logic [255:0] data; int cyc; bit ok;
        do_reset();
        i_read = 1; i_address = 32'h800;
        wait_resp(0, data, cyc, ok);
        i_read = 0;
        mem_lat = 20;
        d_write = 1; d_address = 32'h700; d_wdata = {8{$urandom}};
        repeat (3) @(negedge clk);
        n_tests++;
        if (pmem_write !== 1'b1) begin n_fail++; $display("FAIL mid_pre got wr=%b required 1", pmem_write); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (pmem_write !== 1'b0 || dut.state !== IDLE) begin
            n_fail++; $display("FAIL mid_abort got wr=%b state=%0d required wr=0 state=0", pmem_write, dut.state);
        end
        n_tests++;
        if (i_grant_cnt !== 0 || d_grant_cnt !== 0) begin
            n_fail++; $display("FAIL mid_counts got i=%0d d=%0d required 0 0", i_grant_cnt, d_grant_cnt);
        end
        clear_inputs();
        mem_lat = 5;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin n_fail++; $display("FAIL mid_idle got rd=%b wr=%b required 0 0", pmem_read, pmem_write); end
    endtask

    task automatic test_wrap();
        logic [255:0] data; int cyc; bit ok;
        do_reset();
        @(negedge clk);
        force dut.d_grant_cnt = 32'hFFFF_FFFF;
        #1 release dut.d_grant_cnt;
        @(negedge clk);
        n_tests++;
        if (d_grant_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload got %h required ffffffff", d_grant_cnt); end
        d_read = 1; d_address = 32'h900;
        wait_resp(1, data, cyc, ok);
        d_read = 0;
        @(negedge clk);
        n_tests++;
        if (d_grant_cnt !== 0 || i_grant_cnt !== 0) begin
            n_fail++; $display("FAIL wrap_result got d=%h i=%h required 0 0", d_grant_cnt, i_grant_cnt);
        end
    endtask

    task automatic i_proc(input int n);
        logic [255:0] data; int cyc; bit ok; logic [31:0] a;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = 32'h1000 + ($urandom_range(0, 7) << 5);
            i_read = 1; i_address = a;
            wait_resp(0, data, cyc, ok);
            n_tests++;
            if (data !== ref_line(a)) begin n_fail++; $display("FAIL rand_idata a=%h got %h required %h", a, data, ref_line(a)); end
            n_tests++;
            if (cyc > 18) begin n_fail++; $display("FAIL rand_iwait got %0d cycles required <= 18", cyc); end
            i_read = 0;
            if (ok) i_done++;
        end
    endtask

    task automatic d_proc(input int n);
        logic [255:0] data, wd; int cyc; bit ok; bit wr; logic [31:0] a;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a  = 32'h1000 + ($urandom_range(0, 7) << 5);
            wr = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            d_address = a; d_wdata = wd;
            if (wr) d_write = 1; else d_read = 1;
            wait_resp(1, data, cyc, ok);
            if (wr) begin
                ref_mem[a] = wd;
            end else begin
                n_tests++;
                if (data !== ref_line(a)) begin n_fail++; $display("FAIL rand_ddata a=%h got %h required %h", a, data, ref_line(a)); end
            end
            n_tests++;
            if (cyc > 18) begin n_fail++; $display("FAIL rand_dwait got %0d cycles required <= 18", cyc); end
            d_read = 0; d_write = 0;
            if (ok) d_done++;
        end
    endtask

    task automatic test_random();
        do_reset();
        mem_lat = 3; rand_lat = 1'b1;
        i_done = 0; d_done = 0;
        fork
            i_proc(30);
            d_proc(30);
        join
        @(negedge clk);
        n_tests++;
        if (i_grant_cnt !== 32'(i_done) || d_grant_cnt !== 32'(d_done)) begin
            n_fail++; $display("FAIL rand_counts got i=%0d d=%0d required %0d %0d", i_grant_cnt, d_grant_cnt, i_done, d_done);
        end
        rand_lat = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lone_iread();
        test_tie();
        test_writeback();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
